// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle multiply/divide engine and HI/LO owner.
//
// Handles MULT/MULTU/DIV/DIVU with a radix-2 shift-add multiplier and a
// restoring divider, plus MTHI/MTLO/MFHI/MFLO. While a multiply or divide
// is in flight, any further HI/LO instruction is stalled.
//
// Ports:
//   clock_i, reset_i         clock, asynchronous active-high reset
//   op_valid_i, op_i         instruction valid and funct code
//   param_1_i, param_2_i     rs / rt operands
//   busy_o                   engine not idle (registered)
//   stall_o                  hold the current instruction (combinational)
//   result_o, result_valid_o MFHI/MFLO read data (combinational)
//   div_by_zero_o            one-cycle pulse when a divide by zero completes
//   hi_o, lo_o               HI/LO registers
//
// Optional feature: define MULDIV_EARLY_OUT_EN to let a multiply finish as
// soon as the remaining multiplier magnitude is zero.
module muldiv_sequencer #(
    parameter int GPR_BITS = 32,
    parameter int CNT_BITS = 6
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic                op_valid_i,
    input  logic [5:0]          op_i,
    input  logic [GPR_BITS-1:0] param_1_i,
    input  logic [GPR_BITS-1:0] param_2_i,
    output logic                busy_o,
    output logic                stall_o,
    output logic [GPR_BITS-1:0] result_o,
    output logic                result_valid_o,
    output logic                div_by_zero_o,
    output logic [GPR_BITS-1:0] hi_o,
    output logic [GPR_BITS-1:0] lo_o
);

    localparam int W  = GPR_BITS;
    localparam int W2 = 2 * GPR_BITS;

    localparam logic [5:0] FUNCT_MFHI = 6'h10;
    localparam logic [5:0] FUNCT_MTHI = 6'h11;
    localparam logic [5:0] FUNCT_MFLO = 6'h12;
    localparam logic [5:0] FUNCT_MTLO = 6'h13;
    localparam logic [5:0] FUNCT_MUL  = 6'h18;
    localparam logic [5:0] FUNCT_MULU = 6'h19;
    localparam logic [5:0] FUNCT_DIV  = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU = 6'h1B;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL_ITER,
        ST_DIV_ITER,
        ST_SIGN_FIX
    } state_t;

    state_t              state_q;
    logic                busy_q;
    logic                dbz_q;
    logic                op_div_q;
    logic                sign_a_q;
    logic                sign_b_q;
    logic [W-1:0]        hi_q;
    logic [W-1:0]        lo_q;
    // Multiply: multiplier. Divide: divisor (never shifted).
    logic [W-1:0]        mplier_q;
    // Multiply: product accumulator. Divide: {remainder, quotient}.
    logic [W2-1:0]       acc_q;
    // Multiply: shifting multiplicand. Divide: dividend magnitude kept for
    // the divide-by-zero HI value.
    logic [W2-1:0]       mcand_q;
    logic [CNT_BITS-1:0] cnt_q;

    // Decode
    logic is_mul, is_div, is_mt, is_mf, is_signed, hilo_op, accept;

    assign is_mul    = (op_i == FUNCT_MUL) || (op_i == FUNCT_MULU);
    assign is_div    = (op_i == FUNCT_DIV) || (op_i == FUNCT_DIVU);
    assign is_mt     = (op_i == FUNCT_MTHI) || (op_i == FUNCT_MTLO);
    assign is_mf     = (op_i == FUNCT_MFHI) || (op_i == FUNCT_MFLO);
    assign is_signed = (op_i == FUNCT_MUL) || (op_i == FUNCT_DIV);
    assign hilo_op   = op_valid_i && (is_mul || is_div || is_mt || is_mf);
    assign accept    = hilo_op && !busy_q;

    // Operand magnitudes
    logic         neg_a, neg_b;
    logic [W-1:0] mag_a, mag_b;

    assign neg_a = is_signed && param_1_i[W-1];
    assign neg_b = is_signed && param_2_i[W-1];
    assign mag_a = neg_a ? -param_1_i : param_1_i;
    assign mag_b = neg_b ? -param_2_i : param_2_i;

    // One shift-add multiply step
    logic [W2-1:0] mul_acc_d;
    logic [W-1:0]  mul_mplier_d;

    assign mul_acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign mul_mplier_d = mplier_q >> 1;

    // One restoring divide step; the extra bit of rem_shift catches the
    // remainder bit shifted out before the trial subtract.
    logic [W:0]    rem_shift, rem_diff;
    logic [W2-1:0] div_acc_d;

    assign rem_shift = {acc_q[W2-1:W], acc_q[W-1]};
    assign rem_diff  = rem_shift - {1'b0, mplier_q};
    assign div_acc_d = rem_diff[W] ? {rem_shift[W-1:0], acc_q[W-2:0], 1'b0}
                                   : {rem_diff[W-1:0],  acc_q[W-2:0], 1'b1};

    logic last_iter, mul_done;

    assign last_iter = (cnt_q == CNT_BITS'(GPR_BITS - 1));
`ifdef MULDIV_EARLY_OUT_EN
    assign mul_done = last_iter || (mul_mplier_d == '0);
`else
    assign mul_done = last_iter;
`endif

    // Sign correction
    logic [W2-1:0] prod_fix;
    logic [W-1:0]  quo_fix, rem_fix, dvd_orig;
    logic          div_zero;

    assign prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    assign quo_fix  = (sign_a_q ^ sign_b_q) ? -acc_q[W-1:0] : acc_q[W-1:0];
    assign rem_fix  = sign_a_q ? -acc_q[W2-1:W] : acc_q[W2-1:W];
    assign dvd_orig = sign_a_q ? -mcand_q[W-1:0] : mcand_q[W-1:0];
    assign div_zero = (mplier_q == '0);

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            dbz_q    <= 1'b0;
            op_div_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            cnt_q    <= '0;
        end else begin
            dbz_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (is_mul || is_div) begin
                            sign_a_q <= neg_a;
                            sign_b_q <= neg_b;
                            op_div_q <= is_div;
                            cnt_q    <= '0;
                            mplier_q <= mag_b;
                            mcand_q  <= {{W{1'b0}}, mag_a};
                            acc_q    <= is_div ? {{W{1'b0}}, mag_a} : '0;
                            state_q  <= is_div ? ST_DIV_ITER : ST_MUL_ITER;
                            busy_q   <= 1'b1;
                        end else if (op_i == FUNCT_MTHI) begin
                            hi_q <= param_1_i;
                        end else if (op_i == FUNCT_MTLO) begin
                            lo_q <= param_1_i;
                        end
                    end
                end
                ST_MUL_ITER: begin
                    acc_q    <= mul_acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mul_mplier_d;
                    cnt_q    <= cnt_q + CNT_BITS'(1);
                    if (mul_done) state_q <= ST_SIGN_FIX;
                end
                ST_DIV_ITER: begin
                    acc_q <= div_acc_d;
                    cnt_q <= cnt_q + CNT_BITS'(1);
                    if (last_iter) state_q <= ST_SIGN_FIX;
                end
                ST_SIGN_FIX: begin
                    if (op_div_q) begin
                        if (div_zero) begin
                            lo_q  <= '1;
                            hi_q  <= dvd_orig;
                            dbz_q <= 1'b1;
                        end else begin
                            lo_q <= quo_fix;
                            hi_q <= rem_fix;
                        end
                    end else begin
                        hi_q <= prod_fix[W2-1:W];
                        lo_q <= prod_fix[W-1:0];
                    end
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o         = busy_q;
    assign stall_o        = hilo_op && busy_q;
    assign result_valid_o = accept && is_mf;
    assign result_o       = result_valid_o ? ((op_i == FUNCT_MFHI) ? hi_q : lo_q) : '0;
    assign div_by_zero_o  = dbz_q;
    assign hi_o           = hi_q;
    assign lo_o           = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADD   = 6'h20;

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY_OUT = 1'b1;
`else
    localparam bit EARLY_OUT = 1'b0;
`endif

    logic        clock_i = 1'b0;
    logic        reset_i;
    logic        op_valid_i;
    logic [5:0]  op_i;
    logic [31:0] param_1_i, param_2_i;
    logic        busy_o, stall_o, result_valid_o, div_by_zero_o;
    logic [31:0] result_o, hi_o, lo_o;

    muldiv_sequencer #(.GPR_BITS(32), .CNT_BITS(6)) dut (
        .clock_i        (clock_i),
        .reset_i        (reset_i),
        .op_valid_i     (op_valid_i),
        .op_i           (op_i),
        .param_1_i      (param_1_i),
        .param_2_i      (param_2_i),
        .busy_o         (busy_o),
        .stall_o        (stall_o),
        .result_o       (result_o),
        .result_valid_o (result_valid_o),
        .div_by_zero_o  (div_by_zero_o),
        .hi_o           (hi_o),
        .lo_o           (lo_o)
    );

    always #5 clock_i = ~clock_i;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } vec_t;

    vec_t vecs[12];
    int   pass_cnt = 0;
    int   total_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic v, input logic [5:0] o, input logic [31:0] x, input logic [31:0] y);
        @(posedge clock_i);
        #1;
        op_valid_i = v;
        op_i       = o;
        param_1_i  = x;
        param_2_i  = y;
    endtask

    // Busy length for a multiply/divide, from the multiplier magnitude.
    function automatic int exp_busy(input logic [5:0] o, input logic [31:0] b);
        logic [31:0] mag;
        mag = (o == F_MULT && b[31]) ? -b : b;
        if (EARLY_OUT && (o == F_MULT || o == F_MULTU)) begin
            if (mag == 0) return 2;
            for (int i = 31; i >= 0; i--)
                if (mag[i]) return i + 2;
        end
        return 33;
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        int cycles;
        string tag;
        tag = $sformatf("vec%0d", idx);
        drive(1'b1, v.op, v.a, v.b);
        drive(1'b0, F_ADD, 32'h0, 32'h0);
        cycles = 0;
        @(negedge clock_i);
        while (busy_o && cycles < 200) begin
            cycles++;
            @(negedge clock_i);
        end
        check({tag, "_busy_cycles"}, 64'(cycles), 64'(exp_busy(v.op, v.b)));
        check({tag, "_hi"}, {32'h0, hi_o}, {32'h0, v.hi});
        check({tag, "_lo"}, {32'h0, lo_o}, {32'h0, v.lo});
        check({tag, "_dbz"}, {63'h0, div_by_zero_o}, {63'h0, v.dbz});
    endtask

    initial begin
        int n, bad;

        vecs[0]  = '{F_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0};
        vecs[1]  = '{F_MULTU, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA, 1'b0};
        vecs[2]  = '{F_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3]  = '{F_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 1'b1};
        vecs[4]  = '{F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[5]  = '{F_MULTU, 32'h00000005, 32'h00000003, 32'h00000000, 32'h0000000F, 1'b0};
        vecs[6]  = '{F_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0};
        vecs[7]  = '{F_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[8]  = '{F_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[9]  = '{F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[10] = '{F_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
        vecs[11] = '{F_MULT,  32'h00000007, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0};

        reset_i    = 1'b1;
        op_valid_i = 1'b0;
        op_i       = 6'h0;
        param_1_i  = 32'h0;
        param_2_i  = 32'h0;
        repeat (3) @(posedge clock_i);
        #1 reset_i = 1'b0;

        @(negedge clock_i);
        check("rst_busy", {63'h0, busy_o}, 64'h0);
        check("rst_hi", {32'h0, hi_o}, 64'h0);
        check("rst_lo", {32'h0, lo_o}, 64'h0);
        check("rst_dbz", {63'h0, div_by_zero_o}, 64'h0);

        drive(1'b1, F_MFHI, 32'h0, 32'h0);
        @(negedge clock_i);
        check("mfhi_rst_result", {32'h0, result_o}, 64'h0);
        check("mfhi_rst_valid", {63'h0, result_valid_o}, 64'h1);
        check("mfhi_rst_stall", {63'h0, stall_o}, 64'h0);
        drive(1'b1, F_MFLO, 32'h0, 32'h0);
        @(negedge clock_i);
        check("mflo_rst_result", {32'h0, result_o}, 64'h0);
        check("mflo_rst_valid", {63'h0, result_valid_o}, 64'h1);
        check("mflo_rst_stall", {63'h0, stall_o}, 64'h0);
        drive(1'b0, F_ADD, 32'h0, 32'h0);

        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        // MFLO issued while a multiply is in flight, with an ADD in between.
        drive(1'b1, F_MULTU, 32'h00000003, 32'hFFFFFFFE);
        drive(1'b1, F_ADD, 32'h1, 32'h2);
        @(negedge clock_i);
        check("add_busy", {63'h0, busy_o}, 64'h1);
        check("add_no_stall", {63'h0, stall_o}, 64'h0);
        repeat (3) drive(1'b0, F_ADD, 32'h0, 32'h0);
        drive(1'b1, F_MFLO, 32'h0, 32'h0);
        n = 0;
        bad = 0;
        @(negedge clock_i);
        while (busy_o && n < 100) begin
            if (!stall_o || result_valid_o) bad++;
            n++;
            @(negedge clock_i);
        end
        check("mflo_stalled_while_busy", 64'(bad), 64'h0);
        check("mflo_wait_bounded", {63'h0, busy_o}, 64'h0);
        check("mflo_released_stall", {63'h0, stall_o}, 64'h0);
        check("mflo_released_valid", {63'h0, result_valid_o}, 64'h1);
        check("mflo_released_result", {32'h0, result_o}, 64'hFFFFFFFA);
        check("mflo_released_hi", {32'h0, hi_o}, 64'h2);

        // MTHI/MTLO followed immediately by the matching move-from.
        drive(1'b1, F_MTHI, 32'h12345678, 32'h0);
        drive(1'b1, F_MFHI, 32'h0, 32'h0);
        @(negedge clock_i);
        check("mthi_mfhi_result", {32'h0, result_o}, 64'h12345678);
        check("mthi_mfhi_valid", {63'h0, result_valid_o}, 64'h1);
        drive(1'b1, F_MTLO, 32'hCAFEF00D, 32'h0);
        drive(1'b1, F_MFLO, 32'h0, 32'h0);
        @(negedge clock_i);
        check("mtlo_mflo_result", {32'h0, result_o}, 64'hCAFEF00D);
        check("mt_hi_kept", {32'h0, hi_o}, 64'h12345678);

        // Reset in the middle of a divide-by-zero: no pulse may follow.
        drive(1'b1, F_DIVU, 32'h5, 32'h0);
        drive(1'b0, F_ADD, 32'h0, 32'h0);
        repeat (9) @(posedge clock_i);
        #1 reset_i = 1'b1;
        #1;
        check("midrst_busy", {63'h0, busy_o}, 64'h0);
        check("midrst_hi", {32'h0, hi_o}, 64'h0);
        check("midrst_lo", {32'h0, lo_o}, 64'h0);
        @(posedge clock_i);
        #1 reset_i = 1'b0;
        bad = 0;
        repeat (40) begin
            @(negedge clock_i);
            if (busy_o || div_by_zero_o) bad++;
        end
        check("midrst_quiet_after", 64'(bad), 64'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle multiply/divide engine and HI/LO owner for the execute stage; it replaces the single-cycle `*`, `/` and `%` paths in the ALU.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO by funct code and runs radix-2 iterative shift-add multiply or restoring divide under an FSM.
- Stalls the pipeline while a HI/LO operation is in flight.

Parameters:
- GPR_BITS, 32, operand width; HI and LO are each GPR_BITS wide, the product is 2*GPR_BITS.
- CNT_BITS, 6, iteration counter width; must satisfy 2^CNT_BITS > GPR_BITS.

Ports:
- clock_i  in  1  clock; all state updates on rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- op_valid_i  in  1  execute stage presents a valid instruction this cycle.
- op_i  in  6  funct code (FUNCT_MUL, FUNCT_MULu, FUNCT_DIV, FUNCT_DIVu, FUNCT_MTHI, FUNCT_MTLO, FUNCT_MFHI, FUNCT_MFLO); any other code is ignored.
- param_1_i  in  GPR_BITS  rs value (multiplicand / dividend / MTxx source).
- param_2_i  in  GPR_BITS  rt value (multiplier / divisor).
- busy_o  out  1  registered; high while state != IDLE.
- stall_o  out  1  combinational; pipeline must hold the instruction.
- result_o  out  GPR_BITS  combinational HI or LO for MFHI/MFLO; 0 otherwise.
- result_valid_o  out  1  combinational; result_o is valid this cycle.
- div_by_zero_o  out  1  registered one-cycle pulse on completion of a DIV/DIVU whose divisor was 0.
- hi_o, lo_o  out  GPR_BITS each  registered HI/LO contents.

Behaviour:
- Reset, asynchronous: state=IDLE; HI, LO, accumulators and counter = 0; busy_o=0; div_by_zero_o=0.
- hilo_op = op_valid_i and op_i in {MUL, MULu, DIV, DIVu, MTHI, MTLO, MFHI, MFLO}.
- stall_o = hilo_op & busy_o. No op is accepted while stalled.
- Accept cycle (IDLE, hilo_op, no stall):
  - MUL/MULu/DIV/DIVu: latch operand magnitudes, sign flags and op kind. Unsigned ops take raw operands with sign flags = 0. Counter=0. Next state is MUL_ITER or DIV_ITER.
  - MTHI/MTLO: write HI/LO from param_1_i at this edge; stay IDLE.
  - MFHI/MFLO: result_o = HI/LO, result_valid_o=1 in the same cycle; no state change.
- MUL_ITER:
  - Each cycle: if multiplier LSB is 1, add shifted multiplicand into the 2*GPR_BITS accumulator; shift the multiplier right and the multiplicand left; counter++.
  - Leave after GPR_BITS iterations to SIGN_FIX.
- DIV_ITER (restoring):
  - Each cycle: shift remainder:quotient left by 1; trial-subtract divisor; if non-negative keep the difference and set quotient LSB; counter++.
  - Leave after GPR_BITS iterations to SIGN_FIX.
- SIGN_FIX (1 cycle): write HI/LO at this edge, then return to IDLE.
  - MUL: product negated if sign flags differ.
  - DIV: quotient negated if sign flags differ; remainder negated if dividend was negative.
- Latency: busy_o high exactly GPR_BITS+1 cycles (33) starting the cycle after accept. New HI/LO are visible on hi_o/lo_o in the first cycle busy_o=0. A hilo_op presented then is accepted with no bubble.
- Divide by zero: iterate normally (timing unchanged). SIGN_FIX forces LO = all ones, HI = original param_1_i, and pulses div_by_zero_o.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (falls out of the magnitude algorithm with GPR_BITS truncation).
- Non-hilo ops never stall, including while busy; they do not affect this block.
- Reset asserted mid-operation: immediate return to IDLE, HI/LO cleared, no div_by_zero_o pulse.

Optional Feature:
- Macro MULDIV_EARLY_OUT_EN.
- Defined: MUL_ITER also exits to SIGN_FIX at the end of any iteration that leaves the remaining multiplier magnitude 0. Minimum 1 iteration, so busy_o lasts 1 + index of highest set bit of |multiplier| + 1 cycles (minimum 2). DIV timing is unchanged.
- Undefined: fixed GPR_BITS+1 busy cycles for both MUL and DIV.

Test Plan:
- Reset, then MFHI and MFLO -> result_o=0, result_valid_o=1, stall_o=0.
- MULT 0xFFFFFFFE, 0x00000003 -> busy_o high 33 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV 0xFFFFFFF9 (-7), 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7, 0 -> LO=0xFFFFFFFF, HI=7, one div_by_zero_o pulse.
- MFLO issued 5 cycles after MULT accept -> stall_o=1 until busy_o falls; in that cycle result_o = new LO; an ADD issued during busy -> stall_o=0.
- MTHI 0x12345678 then MFHI next cycle -> 0x12345678. Assert reset_i at iteration 10 of a DIV -> busy_o=0 and HI=LO=0 immediately.
- With MULDIV_EARLY_OUT_EN: MULTU 5, 3 -> busy_o high 3 cycles, LO=15. Without: 33 cycles.
